// File: rtl/cascaded_time_counter.sv
// ============================================================================
// cascaded_time_counter
//
// Chain of NUM_STAGES modulo counters sharing one count enable, used for the
// watch / stopwatch / timer datapath (e.g. hours:minutes:seconds.centiseconds).
// The carry between stages is combinational, so a full rollover such as
// 23:59:59.99 -> 00:00:00.00 happens on a single clock edge.
//
// Parameters:
//   NUM_STAGES        number of stages, stage 0 is least significant
//   STAGE_W           bit width of each stage
//   MODULI            packed per-stage modulus, stage k at [k*STAGE_W +: STAGE_W]
//   INIT_VALUES       packed per-stage value used on reset and clear
//   DOWN_STOP_AT_ZERO 1 = down count halts at all-zero, 0 = down count wraps
//   SEL_W             width of the load stage select
//
// Ports:
//   clk           clock
//   reset         asynchronous, active-high reset
//   i_tick        one-cycle count enable
//   i_run         1 = count on i_tick, 0 = hold
//   i_mode        0 = count up, 1 = count down
//   i_clear       synchronous clear to INIT_VALUES
//   i_load        synchronous load strobe for one stage
//   i_load_sel    stage targeted by the load
//   i_load_value  value to load (clamped to modulus-1)
//   o_count       packed registered stage values
//   o_carry       one-cycle pulse when the top stage wraps
//   o_zero        all stages are zero (decoded from the count registers)
//   o_expired     one-cycle pulse when a down count reaches all-zero
// ============================================================================
module cascaded_time_counter #(
    parameter int                              NUM_STAGES        = 4,
    parameter int                              STAGE_W           = 7,
    parameter logic [NUM_STAGES*STAGE_W-1:0]   MODULI            = {7'd24, 7'd60, 7'd60, 7'd100},
    parameter logic [NUM_STAGES*STAGE_W-1:0]   INIT_VALUES       = '0,
    parameter bit                              DOWN_STOP_AT_ZERO = 1'b1,
    parameter int                              SEL_W             = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               i_tick,
    input  logic                               i_run,
    input  logic                               i_mode,
    input  logic                               i_clear,
    input  logic                               i_load,
    input  logic [SEL_W-1:0]                   i_load_sel,
    input  logic [STAGE_W-1:0]                 i_load_value,
    output logic [NUM_STAGES*STAGE_W-1:0]      o_count,
    output logic                               o_carry,
    output logic                               o_zero,
    output logic                               o_expired
);

    localparam logic [STAGE_W-1:0] ONE = STAGE_W'(1);

    logic [NUM_STAGES*STAGE_W-1:0] r_count;
    logic                          r_carry;
    logic                          r_expired;

    logic [NUM_STAGES-1:0]         w_atMax;
    logic [NUM_STAGES-1:0]         w_atZero;
    logic [NUM_STAGES-1:0]         w_terminal;
    logic [NUM_STAGES-1:0]         w_advance;
    logic                          w_allZero;
    logic                          w_halt;
    logic                          w_doStep;
    logic [NUM_STAGES*STAGE_W-1:0] w_stepCount;
    logic                          w_wrapTop;
    logic                          w_expire;
    logic [NUM_STAGES*STAGE_W-1:0] w_countNext;
    logic                          w_carryNext;
    logic                          w_expiredNext;

    // Per-stage terminal detection and the ripple enable chain. A stage
    // advances only when the step is live and every lower stage sits at its
    // terminal value for the current direction (M-1 going up, 0 going down).
    // A down step from all-zero is suppressed entirely in timer configuration.
    always_comb begin
        w_atMax    = '0;
        w_atZero   = '0;
        w_terminal = '0;
        w_advance  = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            w_atMax[k]    = (r_count[k*STAGE_W +: STAGE_W] == (MODULI[k*STAGE_W +: STAGE_W] - ONE));
            w_atZero[k]   = (r_count[k*STAGE_W +: STAGE_W] == '0);
            w_terminal[k] = i_mode ? w_atZero[k] : w_atMax[k];
        end
        w_allZero    = &w_atZero;
        w_halt       = DOWN_STOP_AT_ZERO && i_mode && w_allZero;
        w_doStep     = i_tick && i_run && !w_halt;
        w_advance[0] = w_doStep;
        for (int k = 1; k < NUM_STAGES; k++) begin
            w_advance[k] = w_advance[k-1] && w_terminal[k-1];
        end
    end

    // Stepped value of every stage. Wrapping is handled by explicit compare
    // rather than modulo arithmetic so no stage ever holds a value >= modulus.
    always_comb begin
        w_stepCount = r_count;
        for (int k = 0; k < NUM_STAGES; k++) begin
            if (w_advance[k]) begin
                if (i_mode) begin
                    w_stepCount[k*STAGE_W +: STAGE_W] = w_atZero[k]
                        ? (MODULI[k*STAGE_W +: STAGE_W] - ONE)
                        : (r_count[k*STAGE_W +: STAGE_W] - ONE);
                end else begin
                    w_stepCount[k*STAGE_W +: STAGE_W] = w_atMax[k]
                        ? '0
                        : (r_count[k*STAGE_W +: STAGE_W] + ONE);
                end
            end
        end
        w_wrapTop = w_advance[NUM_STAGES-1] && w_terminal[NUM_STAGES-1];
        w_expire  = w_doStep && i_mode && !w_allZero && (w_stepCount == '0);
    end

    // Next-state selection with clear over load over step. Clear and load
    // cycles swallow any step, so they also force both pulses low. A load
    // select outside the stage range matches no stage and is ignored.
    always_comb begin
        w_countNext   = r_count;
        w_carryNext   = 1'b0;
        w_expiredNext = 1'b0;
        if (i_clear) begin
            w_countNext = INIT_VALUES;
        end else if (i_load) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                if (32'(i_load_sel) == k) begin
                    w_countNext[k*STAGE_W +: STAGE_W] =
                        (i_load_value >= MODULI[k*STAGE_W +: STAGE_W])
                        ? (MODULI[k*STAGE_W +: STAGE_W] - ONE)
                        : i_load_value;
                end
            end
        end else if (w_doStep) begin
            w_countNext   = w_stepCount;
            w_carryNext   = w_wrapTop;
            w_expiredNext = w_expire;
        end
    end

    // State registers. Pulses are re-evaluated every cycle, which makes them
    // naturally one cycle wide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count   <= INIT_VALUES;
            r_carry   <= 1'b0;
            r_expired <= 1'b0;
        end else begin
            r_count   <= w_countNext;
            r_carry   <= w_carryNext;
            r_expired <= w_expiredNext;
        end
    end

    // Zero flag decoded straight from the registers so it lines up with o_count.
    always_comb begin
        o_count   = r_count;
        o_carry   = r_carry;
        o_expired = r_expired;
        o_zero    = (r_count == '0);
    end

endmodule

// File: tb/tb_cascaded_time_counter.sv
// ============================================================================
// tb_cascaded_time_counter
//
// Directed bench for cascaded_time_counter in its default hh:mm:ss.cc
// configuration. A table of one-cycle vectors carries most of the checks;
// multi-cycle cases (long tick runs, asynchronous reset) are written by hand.
// ============================================================================
module tb_cascaded_time_counter;

    localparam int NS = 4;
    localparam int SW = 7;
    localparam int SELW = 3;

    logic            clk;
    logic            reset;
    logic            i_tick;
    logic            i_run;
    logic            i_mode;
    logic            i_clear;
    logic            i_load;
    logic [SELW-1:0] i_load_sel;
    logic [SW-1:0]   i_load_value;
    logic [NS*SW-1:0] o_count;
    logic            o_carry;
    logic            o_zero;
    logic            o_expired;

    int assertCount;
    int failCount;

    typedef struct {
        logic            clear;
        logic            load;
        logic [SELW-1:0] sel;
        logic [SW-1:0]   value;
        logic            tick;
        logic            run;
        logic            mode;
        logic [NS*SW-1:0] expCount;
        logic            expCarry;
        logic            expExpired;
        logic            expZero;
        string           name;
    } vec_t;

    vec_t vecs[$];

    cascaded_time_counter #(
        .NUM_STAGES        (NS),
        .STAGE_W           (SW),
        .MODULI            ({7'd24, 7'd60, 7'd60, 7'd100}),
        .INIT_VALUES       ('0),
        .DOWN_STOP_AT_ZERO (1'b1),
        .SEL_W             (SELW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_tick       (i_tick),
        .i_run        (i_run),
        .i_mode       (i_mode),
        .i_clear      (i_clear),
        .i_load       (i_load),
        .i_load_sel   (i_load_sel),
        .i_load_value (i_load_value),
        .o_count      (o_count),
        .o_carry      (o_carry),
        .o_zero       (o_zero),
        .o_expired    (o_expired)
    );

    // Free-running 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Packs hours, minutes, seconds, centiseconds into the stage layout.
    function automatic logic [NS*SW-1:0] hms(input int h, input int m, input int s, input int c);
        return {7'(h), 7'(m), 7'(s), 7'(c)};
    endfunction

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic addVec(input logic clear, input logic load, input int sel, input int value,
                          input logic tick, input logic run, input logic mode,
                          input logic [NS*SW-1:0] expCount, input logic expCarry,
                          input logic expExpired, input logic expZero, input string name);
        vec_t v;
        v.clear      = clear;
        v.load       = load;
        v.sel        = SELW'(sel);
        v.value      = SW'(value);
        v.tick       = tick;
        v.run        = run;
        v.mode       = mode;
        v.expCount   = expCount;
        v.expCarry   = expCarry;
        v.expExpired = expExpired;
        v.expZero    = expZero;
        v.name       = name;
        vecs.push_back(v);
    endtask

    // Drives one vector for exactly one active edge, then settles past it.
    task automatic applyStimulus(input vec_t v);
        i_clear      = v.clear;
        i_load       = v.load;
        i_load_sel   = v.sel;
        i_load_value = v.value;
        i_tick       = v.tick;
        i_run        = v.run;
        i_mode       = v.mode;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input vec_t v);
        checkValue({v.name, ".count"},   32'(o_count),   32'(v.expCount));
        checkValue({v.name, ".carry"},   32'(o_carry),   32'(v.expCarry));
        checkValue({v.name, ".expired"}, 32'(o_expired), 32'(v.expExpired));
        checkValue({v.name, ".zero"},    32'(o_zero),    32'(v.expZero));
    endtask

    initial begin
        assertCount  = 0;
        failCount    = 0;
        reset        = 1'b1;
        i_tick       = 1'b0;
        i_run        = 1'b0;
        i_mode       = 1'b0;
        i_clear      = 1'b0;
        i_load       = 1'b0;
        i_load_sel   = '0;
        i_load_value = '0;

        repeat (2) @(posedge clk);
        #1;
        checkValue("reset.count",   32'(o_count),   32'(0));
        checkValue("reset.zero",    32'(o_zero),    32'(1));
        checkValue("reset.carry",   32'(o_carry),   32'(0));
        checkValue("reset.expired", 32'(o_expired), 32'(0));
        reset = 1'b0;

        // 100 back-to-back up steps: one full centisecond wrap, no top carry.
        i_tick = 1'b1;
        i_run  = 1'b1;
        i_mode = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            checkValue("up100.carry", 32'(o_carry), 32'(0));
        end
        checkValue("up100.count", 32'(o_count), 32'(hms(0, 0, 1, 0)));
        checkValue("up100.zero",  32'(o_zero),  32'(0));

        //      clr  ld sel val tk run md  expected          cy ex zr  name
        addVec(1'b0, 1, 3, 23,  0, 1, 0, hms(23, 0, 1, 0),   0, 0, 0, "load_s3");
        addVec(1'b0, 1, 2, 59,  0, 1, 0, hms(23, 59, 1, 0),  0, 0, 0, "load_s2");
        addVec(1'b0, 1, 1, 59,  0, 1, 0, hms(23, 59, 59, 0), 0, 0, 0, "load_s1");
        addVec(1'b0, 1, 0, 99,  0, 1, 0, hms(23, 59, 59, 99),0, 0, 0, "load_s0");
        addVec(1'b0, 0, 0, 0,   1, 1, 0, hms(0, 0, 0, 0),    1, 0, 1, "full_cascade");
        addVec(1'b0, 0, 0, 0,   0, 1, 0, hms(0, 0, 0, 0),    0, 0, 1, "carry_drop");
        addVec(1'b0, 1, 0, 1,   0, 1, 1, hms(0, 0, 0, 1),    0, 0, 0, "load_one");
        addVec(1'b0, 0, 0, 0,   1, 1, 1, hms(0, 0, 0, 0),    0, 1, 1, "expire");
        addVec(1'b0, 0, 0, 0,   1, 1, 1, hms(0, 0, 0, 0),    0, 0, 1, "stop_hold1");
        addVec(1'b0, 0, 0, 0,   1, 1, 1, hms(0, 0, 0, 0),    0, 0, 1, "stop_hold2");
        addVec(1'b0, 0, 0, 0,   1, 1, 1, hms(0, 0, 0, 0),    0, 0, 1, "stop_hold3");
        addVec(1'b0, 1, 2, 75,  0, 1, 0, hms(0, 59, 0, 0),   0, 0, 0, "load_clamp_s2");
        addVec(1'b0, 1, 5, 10,  0, 1, 0, hms(0, 59, 0, 0),   0, 0, 0, "load_bad_sel");
        addVec(1'b1, 1, 0, 5,   1, 1, 0, hms(0, 0, 0, 0),    0, 0, 1, "clear_prio");
        addVec(1'b0, 1, 0, 7,   1, 1, 0, hms(0, 0, 0, 7),    0, 0, 0, "load_over_step");
        addVec(1'b0, 1, 0, 127, 0, 1, 0, hms(0, 0, 0, 99),   0, 0, 0, "load_clamp_s0");
        addVec(1'b0, 0, 0, 0,   1, 1, 0, hms(0, 0, 1, 0),    0, 0, 0, "up_to_1s");
        addVec(1'b0, 0, 0, 0,   1, 1, 1, hms(0, 0, 0, 99),   0, 0, 0, "mode_switch");
        addVec(1'b0, 1, 1, 59,  0, 1, 0, hms(0, 0, 59, 99),  0, 0, 0, "load_59_99");
        addVec(1'b0, 0, 0, 0,   1, 1, 0, hms(0, 1, 0, 0),    0, 0, 0, "up_minute");
        addVec(1'b0, 0, 0, 0,   1, 1, 1, hms(0, 0, 59, 99),  0, 0, 0, "down_minute");
        addVec(1'b0, 0, 0, 0,   1, 0, 0, hms(0, 0, 59, 99),  0, 0, 0, "run_hold");

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i]);
        end

        // 50 ticks with run low: nothing may move.
        i_clear = 1'b0;
        i_load  = 1'b0;
        i_tick  = 1'b1;
        i_run   = 1'b0;
        i_mode  = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            checkValue("run0.carry", 32'(o_carry), 32'(0));
        end
        checkValue("run0.count", 32'(o_count), 32'(hms(0, 0, 59, 99)));

        // Asynchronous reset between edges, then counting resumes.
        i_run = 1'b1;
        @(posedge clk);
        #1;
        checkValue("pre_reset.count", 32'(o_count), 32'(hms(0, 1, 0, 0)));
        #2;
        reset = 1'b1;
        #1;
        checkValue("async_reset.count", 32'(o_count), 32'(0));
        checkValue("async_reset.zero",  32'(o_zero),  32'(1));
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkValue("post_reset.count", 32'(o_count), 32'(hms(0, 0, 0, 1)));
        checkValue("post_reset.zero",  32'(o_zero),  32'(0));
        i_tick = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/cascaded_time_counter.md
# cascaded_time_counter

Parametrised multi-stage time counter for the watch/stopwatch/timer datapath. It chains NUM_STAGES modulo counters (e.g. centisecond, second, minute, hour) behind one enable tick. Carries ripple combinationally within one clock, so every stage updates on the same edge with no per-stage lag. It supports up/down counting, a per-stage synchronous load, a synchronous clear, and an optional stop-at-zero countdown with an expiry pulse.

## Interface
- NUM_STAGES, 4, number of cascaded stages; stage 0 is least significant.
- STAGE_W, 7, bit width of each stage.
- MODULI, {7'd24,7'd60,7'd60,7'd100}, packed per-stage modulus; stage k occupies bits [k*STAGE_W +: STAGE_W]; each value must be ≥2.
- INIT_VALUES, 0, packed per-stage value applied on reset and clear; each value must be < its modulus.
- DOWN_STOP_AT_ZERO, 1, 1 = down count halts at all-zero (timer); 0 = down count wraps.
- SEL_W, $clog2(NUM_STAGES) (minimum 1), width of the load stage select.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- i_tick  in  1  one-cycle count enable (e.g. a 100 Hz strobe).
- i_run  in  1  1 = count on i_tick; 0 = hold.
- i_mode  in  1  0 = up, 1 = down.
- i_clear  in  1  synchronous clear to INIT_VALUES.
- i_load  in  1  synchronous load strobe.
- i_load_sel  in  SEL_W  target stage for the load.
- i_load_value  in  STAGE_W  value to load.
- o_count  out  NUM_STAGES*STAGE_W  packed stage values, registered.
- o_carry  out  1  registered one-cycle pulse when the top stage wraps (up: M-1→0; down: 0→M-1).
- o_zero  out  1  all stages equal 0; decoded from the count registers.
- o_expired  out  1  registered one-cycle pulse when a down count reaches all-zero.

## Operation
- Step condition: step = i_tick & i_run.
- Stage 0 advances on step.
- Stage k>0 advances when step is true and every lower stage is at its terminal value.
  - Up terminal value: M-1.
  - Down terminal value: 0.
- Up count: a stage at M-1 goes to 0; otherwise it increments.
- Down count: a stage at 0 goes to M-1; otherwise it decrements.
- Stop-at-zero (DOWN_STOP_AT_ZERO=1, i_mode=1):
  - If all stages are 0 when step arrives, nothing changes.
  - o_carry and o_expired stay 0 in that cycle.
- o_expired pulses in the cycle after a down step that moves the count from nonzero to all-zero. This applies in both stop and wrap configurations.
- Load:
  - i_load writes i_load_value into stage i_load_sel only; other stages are unchanged.
  - A value ≥ the stage modulus is clamped to modulus-1.
  - If i_load_sel ≥ NUM_STAGES, the load is ignored.
- Priority (highest first): reset > i_clear > i_load > step.
  - A step in a clear or load cycle is dropped for all stages; no carry or expiry is produced.
- Clear restores INIT_VALUES and zeroes o_carry and o_expired in the same edge.
- A change on i_mode or i_run takes effect at the next step. No partial update occurs.
- Arithmetic: each stage is compared and updated at STAGE_W bits. No intermediate value may exceed modulus-1.

## Timing
- Reset values:
  - o_count = INIT_VALUES.
  - o_carry = 0, o_expired = 0.
  - o_zero = 1 iff INIT_VALUES is all zero.
- Latency: a step sampled at edge N is visible on o_count after edge N. o_carry and o_expired go high on that same edge and drop after edge N+1.
- Full cascade (e.g. 23:59:59.99 → 00:00:00.00) completes in one edge. The carry chain is combinational across stages.
- o_zero is valid in the same cycle as o_count. It has no extra register stage.
- Back-to-back ticks on consecutive cycles are all counted.
- Reset asserted mid-count forces reset values immediately (asynchronous). Counting resumes on the first step after reset is released.

## Test plan
- Reset with defaults → o_count=0, o_zero=1, o_carry=0, o_expired=0. Then 100 steps, up, run → stage0=0, stage1=1, no o_carry.
- Load stage3=23, stage2=59, stage1=59, stage0=99; one up step → all stages 0 on the same edge; o_carry high for exactly 1 cycle; o_zero=1.
- Down mode, stop-at-zero; load 00:00:00.01; step → all zero, o_expired pulses once. Three more steps → count stays 0, no o_expired, no o_carry.
- Load stage2 with value 75 → stage2=59. Load with i_load_sel=5 (NUM_STAGES=4) → no change.
- Same cycle: i_clear=1, i_load=1, i_tick=1 → o_count=INIT_VALUES, o_carry=0. Then i_load and i_tick together → only the load applies.
- i_run=0 with 50 ticks → count unchanged. Switch i_mode mid-sequence at 00:00:01.00, down step → 00:00:00.99.
